// File: rtl/tmds_encoder.sv
// Three-channel DVI TMDS 8b/10b encoder: transition minimisation, DC balancing, control tokens.
// Optional macro TMDS_PIPE_EN adds an output register stage (latency 3 instead of 2).

module tmds_channel (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d,
    input  logic [1:0] c,
    input  logic       de,
    output logic [9:0] sym
);

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [3:0]        n1_d_s;
    logic              use_xnor_s;
    logic [8:0]        q_m_s;
    logic [8:0]        q_m_r;
    logic              de_r;
    logic [1:0]        c_r;
    logic [3:0]        n1_q_s;
    logic signed [4:0] diff_s;
    logic signed [4:0] cnt_r;
    logic signed [4:0] cnt_next_s;
    logic [9:0]        sym_next_s;
    logic [9:0]        sym_r;

    // Stage 1 combinational: choose XOR or XNOR chain to minimise transitions
    always_comb begin : stage1_comb
        logic acc;
        n1_d_s     = popcount8(d);
        use_xnor_s = (n1_d_s > 4'd4) || ((n1_d_s == 4'd4) && !d[0]);
        q_m_s      = 9'd0;
        acc        = d[0];
        q_m_s[0]   = acc;
        for (int i = 1; i < 8; i++) begin
            acc      = acc ^ d[i] ^ use_xnor_s;
            q_m_s[i] = acc;
        end
        q_m_s[8] = ~use_xnor_s;
    end

    // Stage 1 register: q_m with its de and control bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_m_r <= 9'd0;
            de_r  <= 1'b0;
            c_r   <= 2'b00;
        end else begin
            q_m_r <= q_m_s;
            de_r  <= de;
            c_r   <= c;
        end
    end

    // Stage 2 combinational: DC balancing against the running disparity, or control token
    always_comb begin
        n1_q_s     = popcount8(q_m_r[7:0]);
        diff_s     = $signed({n1_q_s, 1'b0}) - 5'sd8;
        sym_next_s = TOKEN_00;
        cnt_next_s = 5'sd0;
        if (!de_r) begin
            case (c_r)
                2'b00:   sym_next_s = TOKEN_00;
                2'b01:   sym_next_s = TOKEN_01;
                2'b10:   sym_next_s = TOKEN_10;
                2'b11:   sym_next_s = TOKEN_11;
                default: sym_next_s = TOKEN_00;
            endcase
            cnt_next_s = 5'sd0;
        end else if ((cnt_r == 5'sd0) || (n1_q_s == 4'd4)) begin
            if (q_m_r[8]) begin
                sym_next_s = {2'b01, q_m_r[7:0]};
                cnt_next_s = cnt_r + diff_s;
            end else begin
                sym_next_s = {2'b10, ~q_m_r[7:0]};
                cnt_next_s = cnt_r - diff_s;
            end
        end else if ((!cnt_r[4] && (n1_q_s > 4'd4)) || (cnt_r[4] && (n1_q_s < 4'd4))) begin
            sym_next_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
            cnt_next_s = cnt_r + $signed({3'b000, q_m_r[8], 1'b0}) - diff_s;
        end else begin
            sym_next_s = {1'b0, q_m_r[8], q_m_r[7:0]};
            cnt_next_s = cnt_r + diff_s - $signed({3'b000, ~q_m_r[8], 1'b0});
        end
    end

    // Stage 2 register: output symbol and running disparity
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_r <= TOKEN_00;
            cnt_r <= 5'sd0;
        end else begin
            sym_r <= sym_next_s;
            cnt_r <= cnt_next_s;
        end
    end

`ifdef TMDS_PIPE_EN
    logic [9:0] sym_pipe_r;

    // Extra output register for timing closure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_pipe_r <= TOKEN_00;
        end else begin
            sym_pipe_r <= sym_r;
        end
    end

    assign sym = sym_pipe_r;
`else
    assign sym = sym_r;
`endif

endmodule

module tmds_encoder #(
    parameter int INV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        de,
    output logic [9:0]  tmds0,
    output logic [9:0]  tmds1,
    output logic [9:0]  tmds2
);

    logic [1:0] sync_c_s;

    // Negative-polarity timings are inverted so that idle sync encodes as c=00
    assign sync_c_s = (INV != 0) ? ~{vsync, hsync} : {vsync, hsync};

    tmds_channel u_ch0 (
        .clk (clk),
        .rst (rst),
        .d   (rgb[7:0]),
        .c   (sync_c_s),
        .de  (de),
        .sym (tmds0)
    );

    tmds_channel u_ch1 (
        .clk (clk),
        .rst (rst),
        .d   (rgb[15:8]),
        .c   (2'b00),
        .de  (de),
        .sym (tmds1)
    );

    tmds_channel u_ch2 (
        .clk (clk),
        .rst (rst),
        .d   (rgb[23:16]),
        .c   (2'b00),
        .de  (de),
        .sym (tmds2)
    );

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed self-checking bench for tmds_encoder (INV=0 main instance, INV=1 second instance).

module tb_tmds_encoder;

`ifdef TMDS_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic [23:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [9:0]  tmds0, tmds1, tmds2;
    logic [9:0]  inv_tmds0, inv_tmds1, inv_tmds2;

    int checks   = 0;
    int failures = 0;

    logic [23:0] v_rgb [0:255];
    logic        v_hs  [0:255];
    logic        v_vs  [0:255];
    logic        v_de  [0:255];
    logic [9:0]  o0 [0:263];
    logic [9:0]  o1 [0:263];
    logic [9:0]  o2 [0:263];
    logic [9:0]  ob [0:263];

    tmds_encoder #(.INV(0)) dut (
        .clk(clk), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
        .tmds0(tmds0), .tmds1(tmds1), .tmds2(tmds2)
    );

    tmds_encoder #(.INV(1)) dut_inv (
        .clk(clk), .rst(rst), .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
        .tmds0(inv_tmds0), .tmds1(inv_tmds1), .tmds2(inv_tmds2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] token(input logic v, input logic h);
        logic [9:0] t;
        case ({v, h})
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] r;
        q = s[9] ? ~s[7:0] : s[7:0];
        r[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return r;
    endfunction

    function automatic int disparity(input logic [9:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 10; i++) n += int'(s[i]);
        return 2 * n - 10;
    endfunction

    // Drives v_* vectors one per clock, then LAT idle cycles; output for vector j lands in o*[j+LAT-1]
    task automatic run_seq(input int n);
        for (int i = 0; i < n + LAT; i++) begin
            if (i < n) begin
                rgb = v_rgb[i]; hsync = v_hs[i]; vsync = v_vs[i]; de = v_de[i];
            end else begin
                rgb = 24'h0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
            end
            @(posedge clk); #1;
            o0[i] = tmds0; o1[i] = tmds1; o2[i] = tmds2; ob[i] = inv_tmds0;
        end
    endtask

    task automatic set_vec(input int i, input logic [23:0] p, input logic d, input logic v, input logic h);
        v_rgb[i] = p; v_de[i] = d; v_vs[i] = v; v_hs[i] = h;
    endtask

    task automatic test_reset;
        rst = 1'b0; de = 1'b1; rgb = $urandom; hsync = 1'b1; vsync = 1'b0;
        #3;
        for (int i = 0; i < 4; i++) begin
            rgb = $urandom; de = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
            @(posedge clk); #1;
            checks++;
            if ({tmds0, tmds1, tmds2, inv_tmds0, inv_tmds1, inv_tmds2} !== {6{10'h354}}) begin
                failures++;
                $display("FAIL reset_hold: got %h %h %h / %h %h %h expected all 354",
                         tmds0, tmds1, tmds2, inv_tmds0, inv_tmds1, inv_tmds2);
            end
        end
        de = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = 24'h0;
        rst = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({tmds0, tmds1, tmds2} !== {3{10'h354}}) begin
                failures++;
                $display("FAIL reset_release cycle %0d: got %h %h %h expected 354", i, tmds0, tmds1, tmds2);
            end
        end
        checks++;
        if (inv_tmds0 !== 10'h2AB) begin
            failures++;
            $display("FAIL reset_release_inv: got %h expected 2ab", inv_tmds0);
        end
    endtask

    task automatic test_control_tokens;
        logic [9:0] exp0 [0:3];
        logic [9:0] expi [0:3];
        exp0[0] = 10'h354; exp0[1] = 10'h0AB; exp0[2] = 10'h154; exp0[3] = 10'h2AB;
        expi[0] = 10'h2AB; expi[1] = 10'h154; expi[2] = 10'h0AB; expi[3] = 10'h354;
        for (int j = 0; j < 4; j++) set_vec(j, 24'hA5C3_3C, 1'b0, 1'(j >> 1), 1'(j));
        run_seq(4);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if ({o0[j+LAT-1], o1[j+LAT-1], o2[j+LAT-1], ob[j+LAT-1]} !==
                {exp0[j], 10'h354, 10'h354, expi[j]}) begin
                failures++;
                $display("FAIL ctrl_token c=%0d: got %h %h %h inv %h expected %h 354 354 inv %h",
                         j, o0[j+LAT-1], o1[j+LAT-1], o2[j+LAT-1], ob[j+LAT-1], exp0[j], expi[j]);
            end
        end
    endtask

    task automatic test_black_field;
        for (int j = 0; j < 6; j++) set_vec(j, 24'h000000, 1'b1, 1'b0, 1'b0);
        run_seq(6);
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (o0[j+LAT-1] !== ((j % 2 == 0) ? 10'h100 : 10'h3FF)) begin
                failures++;
                $display("FAIL black_field px%0d: got %h expected %h", j, o0[j+LAT-1],
                         (j % 2 == 0) ? 10'h100 : 10'h3FF);
            end
        end
    endtask

    task automatic test_white_pixel;
        set_vec(0, 24'h0000FF, 1'b1, 1'b0, 1'b0);
        set_vec(1, 24'h000000, 1'b1, 1'b0, 1'b0);
        run_seq(2);
        checks++;
        if (o0[LAT-1] !== 10'h200) begin
            failures++;
            $display("FAIL white_pixel: got %h expected 200", o0[LAT-1]);
        end
        checks++;
        if (o0[LAT] !== 10'h3FF) begin
            failures++;
            $display("FAIL white_then_black (cnt=-8): got %h expected 3ff", o0[LAT]);
        end
    endtask

    task automatic test_mixed_video;
        logic [9:0] e0 [0:5];
        logic [9:0] e1 [0:5];
        logic [9:0] e2 [0:5];
        set_vec(0, 24'h1055FF, 1'b1, 1'b0, 1'b0);
        set_vec(1, 24'h10F000, 1'b1, 1'b0, 1'b0);
        set_vec(2, 24'h1055FF, 1'b1, 1'b1, 1'b1);
        set_vec(3, 24'h1055FF, 1'b1, 1'b0, 1'b1);
        set_vec(4, 24'h105500, 1'b1, 1'b0, 1'b0);
        e0[0] = 10'h200; e0[1] = 10'h3FF; e0[2] = 10'h200; e0[3] = 10'h0FF; e0[4] = 10'h100; e0[5] = 10'h354;
        e1[0] = 10'h133; e1[1] = 10'h205; e1[2] = 10'h133; e1[3] = 10'h133; e1[4] = 10'h133; e1[5] = 10'h354;
        e2[0] = 10'h1F0; e2[1] = 10'h1F0; e2[2] = 10'h1F0; e2[3] = 10'h1F0; e2[4] = 10'h1F0; e2[5] = 10'h354;
        run_seq(5);
        for (int j = 0; j < 6; j++) begin
            checks++;
            if ({o0[j+LAT-1], o1[j+LAT-1], o2[j+LAT-1]} !== {e0[j], e1[j], e2[j]}) begin
                failures++;
                $display("FAIL mixed_video px%0d: got %h %h %h expected %h %h %h", j,
                         o0[j+LAT-1], o1[j+LAT-1], o2[j+LAT-1], e0[j], e1[j], e2[j]);
            end
            checks++;
            if (ob[j+LAT-1] !== ((j == 5) ? 10'h2AB : e0[j])) begin
                failures++;
                $display("FAIL mixed_video_inv px%0d: got %h expected %h", j, ob[j+LAT-1],
                         (j == 5) ? 10'h2AB : e0[j]);
            end
        end
    endtask

    task automatic test_reset_mid_line;
        rgb = 24'h000000; de = 1'b1; hsync = 1'b0; vsync = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({tmds0, tmds1, tmds2} !== {3{10'h354}}) begin
            failures++;
            $display("FAIL reset_async: got %h %h %h expected 354", tmds0, tmds1, tmds2);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_vec(0, 24'h000000, 1'b1, 1'b0, 1'b0);
        set_vec(1, 24'h0000FF, 1'b1, 1'b0, 1'b0);
        run_seq(2);
        for (int k = 0; k < LAT - 1; k++) begin
            checks++;
            if (o0[k] !== 10'h354) begin
                failures++;
                $display("FAIL reset_flush %0d: got %h expected 354", k, o0[k]);
            end
        end
        checks++;
        if ({o0[LAT-1], o0[LAT]} !== {10'h100, 10'h0FF}) begin
            failures++;
            $display("FAIL reset_first_video: got %h %h expected 100 0ff", o0[LAT-1], o0[LAT]);
        end
    endtask

    task automatic test_round_trip;
        int rd [0:2];
        logic [9:0] s [0:2];
        logic [7:0] exp_d [0:2];
        for (int j = 0; j < 200; j++)
            set_vec(j, 24'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
        run_seq(200);
        rd[0] = 0; rd[1] = 0; rd[2] = 0;
        for (int j = 0; j < 200; j++) begin
            s[0] = o0[j+LAT-1]; s[1] = o1[j+LAT-1]; s[2] = o2[j+LAT-1];
            exp_d[0] = v_rgb[j][7:0]; exp_d[1] = v_rgb[j][15:8]; exp_d[2] = v_rgb[j][23:16];
            if (v_de[j]) begin
                for (int ch = 0; ch < 3; ch++) begin
                    rd[ch] += disparity(s[ch]);
                    checks++;
                    if (decode(s[ch]) !== exp_d[ch]) begin
                        failures++;
                        $display("FAIL round_trip px%0d ch%0d: decoded %h expected %h", j, ch, decode(s[ch]), exp_d[ch]);
                    end
                    checks++;
                    if (rd[ch] > 10 || rd[ch] < -10) begin
                        failures++;
                        $display("FAIL disparity_bound px%0d ch%0d: got %0d expected |d|<=10", j, ch, rd[ch]);
                    end
                end
            end else begin
                rd[0] = 0; rd[1] = 0; rd[2] = 0;
                checks++;
                if ({s[0], s[1], s[2], ob[j+LAT-1]} !==
                    {token(v_vs[j], v_hs[j]), 10'h354, 10'h354, token(~v_vs[j], ~v_hs[j])}) begin
                    failures++;
                    $display("FAIL round_trip_token px%0d: got %h %h %h inv %h expected %h 354 354 inv %h", j,
                             s[0], s[1], s[2], ob[j+LAT-1], token(v_vs[j], v_hs[j]), token(~v_vs[j], ~v_hs[j]));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; rgb = 24'h0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        test_reset;
        test_control_tokens;
        test_black_field;
        test_white_pixel;
        test_mixed_video;
        test_reset_mid_line;
        test_round_trip;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
